// File: rtl/blit_scheduler.sv
// rtl/blit_scheduler.sv - sprite descriptor table walker that launches one blit per valid slot per frame
module blit_scheduler #(
    parameter int NUM_SLOTS = 16,
    parameter int COORD_W   = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_SLOTS)-1:0] wr_idx,
    input  logic [6*COORD_W:0]           wr_data,
    input  logic                         blit_done,
    output logic                         blit_start,
    output logic [COORD_W-1:0]           src_x0,
    output logic [COORD_W-1:0]           src_y0,
    output logic [COORD_W-1:0]           src_x1,
    output logic [COORD_W-1:0]           src_y1,
    output logic [COORD_W-1:0]           dst_x,
    output logic [COORD_W-1:0]           dst_y,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);
    localparam int PTR_W  = $clog2(NUM_SLOTS);
    localparam int DESC_W = 6 * COORD_W;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [NUM_SLOTS-1:0] r_valid;
    logic [DESC_W-1:0]   r_desc [NUM_SLOTS];
    logic [PTR_W-1:0]    r_ptr;
    logic [DESC_W-1:0]   r_out;
    logic                r_blit_start;
    logic                r_frame_done;
    logic                r_busy;
    logic                r_overrun;

    logic                w_hit;
    logic                w_last;
    logic                w_ptr_clr;
    logic                w_ptr_inc;
    logic                w_latch;

    assign w_hit  = r_valid[r_ptr];
    assign w_last = (r_ptr == LAST_SLOT);

    // Coordinate fields carry no reset; only the valid bits gate the scan.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_desc[wr_idx] <= wr_data[DESC_W-1:0];
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ptr_clr = 1'b0;
        w_ptr_inc = 1'b0;
        w_latch   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_next    = S_SCAN;
                    w_ptr_clr = 1'b1;
                end
            end
            S_SCAN: begin
                if (w_hit) begin
                    w_next  = S_ISSUE;
                    w_latch = 1'b1;
                end else if (w_last) begin
                    w_next = S_FINISH;
                end else begin
                    w_ptr_inc = 1'b1;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (blit_done) begin
                    if (w_last) begin
                        w_next = S_FINISH;
                    end else begin
                        w_next    = S_SCAN;
                        w_ptr_inc = 1'b1;
                    end
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Status pulses are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_valid      <= '0;
            r_out        <= '0;
            r_blit_start <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ptr_clr) begin
                r_ptr <= '0;
            end else if (w_ptr_inc) begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
            if (wr_en) begin
                r_valid[wr_idx] <= wr_data[DESC_W];
            end
            if (w_latch) begin
                r_out <= r_desc[r_ptr];
            end
            r_blit_start <= (r_state == S_ISSUE);
            r_frame_done <= (w_next == S_FINISH);
            r_busy       <= (w_next == S_SCAN) || (w_next == S_ISSUE) || (w_next == S_WAIT);
            if (frame_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign blit_start = r_blit_start;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign src_x0     = r_out[6*COORD_W-1:5*COORD_W];
    assign src_y0     = r_out[5*COORD_W-1:4*COORD_W];
    assign src_x1     = r_out[4*COORD_W-1:3*COORD_W];
    assign src_y1     = r_out[3*COORD_W-1:2*COORD_W];
    assign dst_x      = r_out[2*COORD_W-1:COORD_W];
    assign dst_y      = r_out[COORD_W-1:0];

endmodule

// File: tb/tb_blit_scheduler.sv
// tb/tb_blit_scheduler.sv - self-checking bench for blit_scheduler against a pass-level reference model
module tb_blit_scheduler;
    localparam int N  = 16;
    localparam int W  = 10;
    localparam int DW = 6 * W;

    logic          clk;
    logic          reset;
    logic          frame_start;
    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [DW:0]   wr_data;
    logic          blit_done;
    logic          blit_start;
    logic [W-1:0]  src_x0, src_y0, src_x1, src_y1, dst_x, dst_y;
    logic          busy;
    logic          frame_done;
    logic          overrun;
    logic [DW-1:0] desc_o;

    blit_scheduler #(.NUM_SLOTS(N), .COORD_W(W)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .blit_done(blit_done), .blit_start(blit_start),
        .src_x0(src_x0), .src_y0(src_y0), .src_x1(src_x1), .src_y1(src_y1),
        .dst_x(dst_x), .dst_y(dst_y),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    assign desc_o = {src_x0, src_y0, src_x1, src_y1, dst_x, dst_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            r;
    logic          m_valid [N];
    logic [DW-1:0] m_desc  [N];
    logic          m_overrun;
    int            pass_slots[$];
    int            mw_n;
    int            mw_cyc [2];
    int            mw_ix  [2];
    logic [DW:0]   mw_dt  [2];
    int            extra_fs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (pass cycle %0d)", tag, obs, exp, r);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic bs, input logic fd, input logic bz);
        chk({tag, "_blit_start"}, 64'(blit_start), 64'(bs));
        chk({tag, "_frame_done"}, 64'(frame_done), 64'(fd));
        chk({tag, "_busy"},       64'(busy),       64'(bz));
        chk({tag, "_overrun"},    64'(overrun),    64'(m_overrun));
    endtask

    function automatic logic [DW:0] mk(input logic v, input int a, input int b, input int c,
                                       input int d, input int e, input int f);
        return {v, W'(a), W'(b), W'(c), W'(d), W'(e), W'(f)};
    endfunction

    function automatic logic [DW:0] rnd_desc(input logic v);
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        return {v, x[DW-1:0]};
    endfunction

    task automatic m_write(input int idx, input logic [DW:0] d);
        m_valid[idx] = d[DW];
        m_desc[idx]  = d[DW-1:0];
    endtask

    task automatic write_slot(input int idx, input logic [DW:0] d);
        wr_en = 1'b1; wr_idx = 4'(idx); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        m_write(idx, d);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_overrun = 1'b0;
        mw_n = 0;
        extra_fs = -1;
    endtask

    // One clock of pass stimulus: scheduled writes land in the model before the edge.
    task automatic step_cycle(input logic done, input logic spur);
        logic fs_x;
        fs_x = 1'b0;
        blit_done = done | (spur & ($urandom_range(0, 3) == 0));
        for (int i = 0; i < mw_n; i++) begin
            if (mw_cyc[i] == r) begin
                wr_en = 1'b1; wr_idx = 4'(mw_ix[i]); wr_data = mw_dt[i];
                m_write(mw_ix[i], mw_dt[i]);
            end
        end
        if (extra_fs == r) begin
            frame_start = 1'b1;
            fs_x = 1'b1;
        end
        @(negedge clk);
        r++;
        if (fs_x) m_overrun = 1'b1;
        frame_start = 1'b0; wr_en = 1'b0; blit_done = 1'b0;
    endtask

    // Pass model: each slot is examined one cycle apart; a hit costs an issue cycle, a
    // launch cycle and the blitter wait before scanning resumes at the following slot.
    task automatic run_pass(input int d_fixed);
        int            p, j, k, d;
        logic          found;
        logic [DW-1:0] exp_desc;
        pass_slots.delete();
        r = 0;
        chk_cycle("idle", 1'b0, 1'b0, 1'b0);
        frame_start = 1'b1;
        step_cycle(1'b0, 1'b1);
        p = 0;
        forever begin
            found = 1'b0;
            exp_desc = '0;
            for (j = p; j < N; j++) begin
                chk_cycle("scan", 1'b0, 1'b0, 1'b1);
                found = m_valid[j];
                exp_desc = m_desc[j];
                step_cycle(1'b0, 1'b1);
                if (found) break;
            end
            if (!found) break;
            k = j;
            pass_slots.push_back(k);
            chk_cycle("issue", 1'b0, 1'b0, 1'b1);
            chk("issue_desc", 64'(desc_o), 64'(exp_desc));
            step_cycle(1'b0, 1'b1);
            d = (d_fixed >= 0) ? d_fixed : int'($urandom_range(0, 6));
            for (int w = 0; w <= d; w++) begin
                chk_cycle("wait", (w == 0), 1'b0, 1'b1);
                chk("wait_desc", 64'(desc_o), 64'(exp_desc));
                step_cycle((w == d), 1'b0);
            end
            if (k == N - 1) break;
            p = k + 1;
        end
        chk_cycle("finish", 1'b0, 1'b1, 1'b0);
        step_cycle(1'b0, 1'b0);
        chk_cycle("post", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; frame_start = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; blit_done = 1'b0;
        r = 0; mw_n = 0; extra_fs = -1; m_overrun = 1'b0;
        for (int i = 0; i < N; i++) begin m_valid[i] = 1'b0; m_desc[i] = '0; end
        @(negedge clk);
        @(negedge clk);
        chk_cycle("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_desc", 64'(desc_o), 64'd0);
        reset = 1'b1;

        // Two valid slots, fixed 10-cycle blitter
        write_slot(0, mk(1, 0, 0, 15, 15, 40, 50));
        write_slot(3, mk(1, 16, 0, 31, 15, 100, 60));
        run_pass(10);
        chk("two_slot_count", 64'(pass_slots.size()), 64'd2);
        chk("two_slot_first", 64'(pass_slots[0]), 64'd0);
        chk("two_slot_second", 64'(pass_slots[1]), 64'd3);

        // Empty table
        write_slot(0, mk(0, 0, 0, 0, 0, 0, 0));
        write_slot(3, mk(0, 0, 0, 0, 0, 0, 0));
        run_pass(-1);
        chk("empty_count", 64'(pass_slots.size()), 64'd0);

        // Last slot only
        write_slot(15, rnd_desc(1'b1));
        run_pass(5);
        chk("last_count", 64'(pass_slots.size()), 64'd1);
        chk("last_slot", 64'(pass_slots[0]), 64'd15);

        // frame_start during WAIT
        write_slot(15, mk(0, 0, 0, 0, 0, 0, 0));
        write_slot(7, rnd_desc(1'b1));
        extra_fs = 12;
        run_pass(6);
        extra_fs = -1;
        chk("overrun_count", 64'(pass_slots.size()), 64'd1);
        chk("overrun_set", 64'(overrun), 64'd1);
        repeat (3) @(negedge clk);
        chk_cycle("overrun_sticky", 1'b0, 1'b0, 1'b0);

        // Reset in WAIT, then a stray blit_done
        do_reset();
        write_slot(0, rnd_desc(1'b1));
        r = 0;
        frame_start = 1'b1;
        step_cycle(1'b0, 1'b0);
        step_cycle(1'b0, 1'b0);
        step_cycle(1'b0, 1'b0);
        chk_cycle("rst_wait", 1'b1, 1'b0, 1'b1);
        do_reset();
        blit_done = 1'b1;
        @(negedge clk);
        blit_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_cycle("rst_after", 1'b0, 1'b0, 1'b0);
            chk("rst_after_desc", 64'(desc_o), 64'd0);
            @(negedge clk);
        end
        run_pass(-1);
        chk("rst_table_cleared", 64'(pass_slots.size()), 64'd0);

        // frame_start on the FINISH cycle of an empty pass
        extra_fs = N + 1;
        run_pass(-1);
        extra_fs = -1;
        chk("finish_fs_overrun", 64'(overrun), 64'd1);

        // Mid-pass edits: later slot joins this pass, earlier slot waits for the next
        do_reset();
        write_slot(2, rnd_desc(1'b1));
        mw_n = 2;
        mw_cyc[0] = 6; mw_ix[0] = 5; mw_dt[0] = rnd_desc(1'b1);
        mw_cyc[1] = 7; mw_ix[1] = 1; mw_dt[1] = rnd_desc(1'b1);
        run_pass(6);
        mw_n = 0;
        chk("edit_count", 64'(pass_slots.size()), 64'd2);
        chk("edit_late_slot", 64'(pass_slots[1]), 64'd5);
        run_pass(2);
        chk("edit_next_count", 64'(pass_slots.size()), 64'd3);
        chk("edit_next_first", 64'(pass_slots[0]), 64'd1);

        // Write to the slot being scanned in the same cycle uses the old contents
        do_reset();
        mw_n = 1; mw_cyc[0] = 5; mw_ix[0] = 4; mw_dt[0] = rnd_desc(1'b1);
        run_pass(-1);
        mw_n = 0;
        chk("same_cycle_count", 64'(pass_slots.size()), 64'd0);
        run_pass(-1);
        chk("same_cycle_next", 64'(pass_slots.size()), 64'd1);

        // Randomized tables, blitter delays, spurious blit_done, mid-pass writes and overruns
        do_reset();
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N; i++) write_slot(i, rnd_desc($urandom_range(0, 3) == 0));
            mw_n = 1;
            mw_cyc[0] = int'($urandom_range(1, 40));
            mw_ix[0]  = int'($urandom_range(0, N - 1));
            mw_dt[0]  = rnd_desc($urandom_range(0, 1) == 1);
            extra_fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
            run_pass(-1);
            mw_n = 0;
            extra_fs = -1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/blit_scheduler.md
BLIT_SCHEDULER -- requirements
Module: blit_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 16, number of sprite descriptor slots (power of two, 2..64).
REQ-002 SHALL have parameter COORD_W, default 10, width of every coordinate field.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse requesting one pass over the table.
REQ-006 SHALL have port wr_en  input  1  descriptor write strobe.
REQ-007 SHALL have port wr_idx  input  log2(NUM_SLOTS)  slot being written.
REQ-008 SHALL have port wr_data  input  6*COORD_W+1  {valid, src_x0, src_y0, src_x1, src_y1, dst_x, dst_y}, valid in MSB.
REQ-009 SHALL have port blit_done  input  1  one-cycle pulse from the blitter: current rectangle finished.
REQ-010 SHALL have port blit_start  output  1  one-cycle pulse launching the blitter.
REQ-011 SHALL have ports src_x0, src_y0, src_x1, src_y1, dst_x, dst_y  output  COORD_W each  registered rectangle handed to the blitter.
REQ-012 SHALL have port busy  output  1  high from pass acceptance until pass end.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at pass end.
REQ-014 SHALL have port overrun  output  1  sticky flag: frame_start arrived while busy.

Function
REQ-015 SHALL store descriptors in a NUM_SLOTS-entry register table written on wr_en, visible to reads on the next cycle.
REQ-016 SHALL implement FSM states IDLE, SCAN, ISSUE, WAIT, FINISH.
REQ-017 IDLE: on frame_start, SHALL clear slot pointer to 0, assert busy, and go to SCAN next cycle.
REQ-018 SCAN: if table[ptr].valid, SHALL latch its six fields into the output registers and go to ISSUE; else increment ptr, one slot per cycle.
REQ-019 SCAN at ptr = NUM_SLOTS-1 with that slot invalid SHALL go to FINISH (no wrap).
REQ-020 ISSUE: SHALL assert blit_start for exactly one cycle, then go to WAIT.
REQ-021 WAIT: outputs SHALL hold stable; on blit_done, if ptr = NUM_SLOTS-1 go to FINISH, else increment ptr and go to SCAN.
REQ-022 blit_done outside WAIT SHALL be ignored.
REQ-023 FINISH: SHALL pulse frame_done one cycle, deassert busy in the same cycle, return to IDLE.
REQ-024 Latency: frame_start with slot 0 valid SHALL give blit_start exactly 3 cycles later (IDLE->SCAN->ISSUE).
REQ-025 Writes during a pass SHALL be accepted; a slot is sampled only when SCAN reads it, so later-slot edits take effect this pass and earlier-slot edits take effect next pass.
REQ-026 Simultaneous wr_en to slot ptr in SCAN SHALL make SCAN use the old table contents.
REQ-027 frame_start while not IDLE SHALL be ignored and SHALL set overrun; overrun clears only on reset.
REQ-028 frame_start coinciding with the FINISH cycle SHALL count as overrun (not queued).
REQ-029 An empty table SHALL produce frame_done NUM_SLOTS+1 cycles after frame_start, with no blit_start.
REQ-030 Coordinates SHALL be passed unmodified; no range or ordering check (src_x1 < src_x0 is the blitter's concern).

Reset
REQ-031 When reset is low at a clock edge: FSM to IDLE, ptr 0, all table valid bits 0, blit_start 0, frame_done 0, busy 0, overrun 0, all coordinate outputs 0.
REQ-032 Reset low mid-pass (including WAIT) SHALL abort the pass with no frame_done; a later blit_done SHALL be ignored.
REQ-033 Table coordinate fields need not reset; only valid bits are required to reset.

Verification
REQ-034 Write slots 0 and 3 valid ({1,0,0,15,15,40,50} and {1,16,0,31,15,100,60}), pulse frame_start, return blit_done 10 cycles after each blit_start -> two blit_start pulses with slot 0 then slot 3 fields, then frame_done once, busy high throughout.
REQ-035 Empty table, frame_start at cycle 0 -> no blit_start, frame_done at cycle NUM_SLOTS+1 (17 with default).
REQ-036 Only slot 15 valid, blit_done after 5 cycles -> single blit_start, frame_done one cycle after blit_done, no pointer wrap.
REQ-037 frame_start pulsed while in WAIT -> overrun = 1 and stays 1, pass completes normally, no second pass.
REQ-038 Reset low for one cycle during WAIT, then blit_done -> busy 0, no frame_done, no blit_start, all table slots invalid.
REQ-039 During pass at slot 2, write slot 5 valid -> slot 5 blitted this pass; write slot 1 valid -> not blitted until next frame_start.
